// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative mul/div sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package muldiv_ctrl_pkg;

  // ALU operation encodings used by the EX-stage ALU.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RSUB = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ANDN = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Mul/div op codes: bit 1 selects divide, bit 0 selects signed.
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  // Sequencer states.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/muldiv_step.sv
// Combinational WIDTH+1-bit add / subtract with carry-out (carry=1 means no borrow).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: a_i, b_i operands; sub_i selects a_i-b_i; sum_o result; cout_o carry out.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           cout_o
);

  // Subtract as a + ~b + 1 so the carry-out doubles as the "a >= b" flag.
  assign {cout_o, sum_o} = {1'b0, a_i}
                         + {1'b0, b_i ^ {(WIDTH+1){sub_i}}}
                         + {{(WIDTH+1){1'b0}}, sub_i};

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, one bit per cycle.
// Latency: done pulses WIDTH+2 edges after the accepting edge (2 for divide by zero).
// Backpressure: busy high in PREP/RUN/FIXUP; start ignored while busy, no queueing.
// Ports: start/op/a/b request; flush aborts; hi_we/lo_we/wdata for MTHI/MTLO;
//        busy, done, div_by_zero status; hi/lo architectural registers.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] ma_q, ma_d;   // |a|: multiplicand / dividend
  logic [WIDTH-1:0] mb_q, mb_d;   // |b|: multiplier / divisor
  logic             sa_q, sa_d;   // operand signs, forced 0 for unsigned ops
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d; // product high / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;   // multiplier shifting out / quotient shifting in
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zdiv_q, zdiv_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div;
  logic             accept;
  logic [WIDTH:0]   step_a, step_b, step_sum, mul_acc;
  logic             step_cout;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign is_div      = op_q[1];
  assign busy        = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIXUP);
  assign accept      = start && !flush && !busy;
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Multiply accumulates |a| into the high half; divide trial-subtracts |b|
  // from the remainder with the next dividend bit shifted in.
  assign step_a = is_div ? {acc_q, sh_q[WIDTH-1]} : {1'b0, acc_q};
  assign step_b = {1'b0, is_div ? mb_q : ma_q};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (step_a),
    .b_i   (step_b),
    .sub_i (is_div),
    .sum_o (step_sum),
    .cout_o(step_cout)
  );

  assign mul_acc  = sh_q[0] ? step_sum : {1'b0, acc_q};
  assign prod     = {acc_q, sh_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

  // Sign fixup of the magnitude result; a zero divisor reports the original a.
  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (zdiv_q) begin
        res_hi = sa_q ? -ma_q : ma_q;
        res_lo = '1;
      end else begin
        res_lo = (sa_q ^ sb_q) ? -sh_q : sh_q;
        res_hi = sa_q ? -acc_q : acc_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    zdiv_d  = zdiv_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_PREP;
          op_d    = op;
          sa_d    = op[0] & a[WIDTH-1];
          sb_d    = op[0] & b[WIDTH-1];
          ma_d    = (op[0] && a[WIDTH-1]) ? -a : a;
          mb_d    = (op[0] && b[WIDTH-1]) ? -b : b;
          dbz_d   = 1'b0;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_PREP: begin
        acc_d = '0;
        cnt_d = '0;
        // A zero divisor skips RUN but still commits through FIXUP so
        // every result shares one write/done path.
        if (is_div && (mb_q == '0)) begin
          zdiv_d  = 1'b1;
          state_d = S_FIXUP;
        end else begin
          zdiv_d  = 1'b0;
          sh_d    = is_div ? ma_q : mb_q;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div) begin
          acc_d = step_cout ? step_sum[WIDTH-1:0] : step_a[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], step_cout};
        end else begin
          acc_d = mul_acc[WIDTH:1];
          sh_d  = {mul_acc[0], sh_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        if (zdiv_q) dbz_d = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything but reset and leaves architectural state alone.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      zdiv_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      zdiv_q  <= zdiv_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed cases plus randomized ops vs. an arithmetic model.
// Latency: checks done arrives WIDTH+2 edges (2 for zero divisor) after the accepting edge.
// Backpressure: stimulus waits for busy low before each start.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0, bad = 0, cyc = 0, ndone = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           k;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  muldiv_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder takes the dividend's sign, which is the MIPS definition.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.k = 0; e.dz = 1'b0; e.lat = W + 2; e.hi = '0; e.lo = '0;
    case (o)
      2'b00: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
      2'b01: begin p = sx * sy; e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
      default: begin
        if (y == '0) begin
          e.dz = 1'b1; e.hi = x; e.lo = '1; e.lat = 2;
        end else if (o == 2'b10) begin
          e.lo = x / y; e.hi = x % y;
        end else begin
          p = sx / sy; e.lo = p[W-1:0];
          p = sx % sy; e.hi = p[W-1:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      ndone++;
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = expq.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_dbz", {31'b0, div_by_zero}, {31'b0, e.dz});
        chk("sb_latency", 32'(cyc - e.k), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL issue_wait actual=busy required=idle");
    end
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(o, x, y);
    e.k = cyc;
    expq.push_back(e);
  endtask

  task automatic wait_done(output int busy_low);
    int n;
    n = 0; busy_low = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      if (!busy) busy_low++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done actual=timeout required=done");
    end
  endtask

  initial begin
    int bl, nd0, n, sel;
    logic [1:0] o;
    logic [W-1:0] x, y;
    exp_t dropped;

    // Reset state, observed asynchronously before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // MULTU max*max, busy throughout, stray start while busy ignored.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #1 op = 2'b10; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(bl);
    chk("multu_busy_low", 32'(bl), 32'd0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(bl);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(bl);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(2'b10, 32'd100, 32'd7);
    wait_done(bl);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // Divide by zero, then the next accepted start clears the sticky flag.
    issue(2'b10, 32'h1234, 32'd0);
    wait_done(bl);
    chk("dz_flag", {31'b0, div_by_zero}, 32'd1);
    chk("dz_hi", hi, 32'h0000_1234);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    issue(2'b10, 32'd100, 32'd7);
    chk("dz_cleared", {31'b0, div_by_zero}, 32'd0);
    chk("prep_busy", {31'b0, busy}, 32'd1);
    wait_done(bl);

    // MTHI/MTLO while idle.
    @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_0001;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_0002;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi", hi, 32'hA5A5_0001);
    chk("mtlo", lo, 32'h5A5A_0002);

    // Flush at RUN cnt=10 (state after edge k+11); MTHI while busy dropped.
    issue(2'b00, $urandom, $urandom);
    dropped = expq.pop_back();
    repeat (2) @(posedge clk);
    #1 hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 hi_we = 1'b0;
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_hi", hi, 32'hA5A5_0001);
    chk("flush_lo", lo, 32'h5A5A_0002);
    nd0 = ndone;
    repeat (40) @(negedge clk);
    chk("flush_no_done", 32'(ndone - nd0), 32'd0);

    // Asynchronous reset mid-RUN, between clock edges.
    issue(2'b00, 32'h0001_2345, 32'h0000_0777);
    dropped = expq.pop_back();
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(2'b00, 32'd3, 32'd5);
    wait_done(bl);
    chk("post_rst_lo", lo, 32'd15);
    chk("post_rst_hi", hi, 32'd0);

    // Randomized back-to-back ops, including zero divisor and 0x80000000 / -1.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = '0;
      else if (sel == 1) begin o = 2'b11; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 15));
      issue(o, x, y);
    end
    n = 0;
    while (expq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_outstanding", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
